imm_ext_arbiter: RTL

Shares the single 8-to-16-bit immediate extender between two requesters. Port A is decode (instruction immediates). Port B is the branch/jump unit (offsets). The block arbitrates round-robin, applies the requested extension mode (zero, sign, upper, two-beat pair), and returns one registered 16-bit result over a valid/ready handshake tagged with the source. It sits between decode/branch logic and the ALU B-operand and PC-offset muxes.

---
 rtl/imm_ext_arbiter_if.sv | 47 ++++
 rtl/imm_ext_arbiter.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/imm_ext_arbiter_if.sv
// Handshake bundle between two immediate requesters, the shared extender and its consumer.
// The interface itself adds no latency and no storage.
// Backpressure: the a/b ready signals and out_ready carry all flow control.
interface imm_ext_arbiter_if #(
  parameter int IMM_W = 8,
  parameter int OUT_W = 16
);
  // requester A (decode immediates)
  logic             a_valid;
  logic             a_ready;
  logic [IMM_W-1:0] a_imm;
  logic [1:0]       a_mode;

  // requester B (branch/jump offsets)
  logic             b_valid;
  logic             b_ready;
  logic [IMM_W-1:0] b_imm;
  logic [1:0]       b_mode;

  // result towards the ALU B-operand / PC-offset muxes
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_src;

  logic             busy;

  // arbiter side
  modport slave (
    input  a_valid, a_imm, a_mode,
    input  b_valid, b_imm, b_mode,
    input  out_ready,
    output a_ready, b_ready,
    output out_valid, out_data, out_src,
    output busy
  );

  // requester / consumer side
  modport master (
    output a_valid, a_imm, a_mode,
    output b_valid, b_imm, b_mode,
    output out_ready,
    input  a_ready, b_ready,
    input  out_valid, out_data, out_src,
    input  busy
  );
endinterface

// File: rtl/imm_ext_arbiter.sv
// Round-robin share of one 8->16 immediate extender between decode (A) and branch (B).
// Latency: result registered one cycle after the accepting beat (PAIR: after the low beat).
// Backpressure: one result in flight; both readies drop until the consumer takes it.
module imm_ext_arbiter #(
  parameter int IMM_W = 8,
  parameter int OUT_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  imm_ext_arbiter_if.slave  bus
);

  // The extension modes concatenate two immediate-wide halves.
  if (OUT_W != 2 * IMM_W) begin : g_bad_width
    $error("imm_ext_arbiter: OUT_W must equal 2*IMM_W");
  end

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PAIR_LO  = 2'd1,
    OUT_HOLD = 2'd2
  } state_t;

  localparam logic [1:0] MODE_ZE   = 2'b00;
  localparam logic [1:0] MODE_SE   = 2'b01;
  localparam logic [1:0] MODE_UP   = 2'b10;
  localparam logic [1:0] MODE_PAIR = 2'b11;

  // Single-beat extension. PAIR never reaches this function; it falls to
  // zero-extension so the case is fully specified.
  function automatic logic [OUT_W-1:0] extend(input logic [1:0]       mode,
                                              input logic [IMM_W-1:0] imm);
    logic [OUT_W-1:0] r;
    case (mode)
      MODE_ZE: r = {{IMM_W{1'b0}}, imm};
      MODE_SE: r = {{IMM_W{imm[IMM_W-1]}}, imm};
      MODE_UP: r = {imm, {IMM_W{1'b0}}};
      default: r = {{IMM_W{1'b0}}, imm};
    endcase
    return r;
  endfunction

  state_t           state;
  logic             ptr;        // 0: A wins a tie, 1: B wins a tie
  logic             owner;      // port that started the pending PAIR
  logic [IMM_W-1:0] hi_byte;    // high half of a pending PAIR
  logic             out_valid_q;
  logic [OUT_W-1:0] out_data_q;
  logic             out_src_q;

  logic             grant_a;
  logic             grant_b;
  logic             accept;
  logic [IMM_W-1:0] sel_imm;
  logic [1:0]       sel_mode;

  // Grant: round-robin tie-break in IDLE, owner locked in PAIR_LO, nobody in OUT_HOLD.
  // A grant already implies the granted port is valid, so grant == accept.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    case (state)
      IDLE: begin
        grant_a = bus.a_valid & (~bus.b_valid | ~ptr);
        grant_b = bus.b_valid & (~bus.a_valid |  ptr);
      end
      PAIR_LO: begin
        grant_a = ~owner & bus.a_valid;
        grant_b =  owner & bus.b_valid;
      end
      default: begin
        grant_a = 1'b0;
        grant_b = 1'b0;
      end
    endcase
  end

  assign accept   = grant_a | grant_b;
  assign sel_imm  = grant_b ? bus.b_imm  : bus.a_imm;
  assign sel_mode = grant_b ? bus.b_mode : bus.a_mode;

  // Readies are combinational from the grant, forced low while reset is held.
  assign bus.a_ready   = reset_n & grant_a;
  assign bus.b_ready   = reset_n & grant_b;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;
  assign bus.busy      = (state != IDLE);

  // Control FSM with registered result; pointer moves only on the output handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      ptr         <= 1'b0;
      owner       <= 1'b0;
      hi_byte     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (sel_mode == MODE_PAIR) begin
              hi_byte <= sel_imm;
              owner   <= grant_b;
              state   <= PAIR_LO;
            end else begin
              out_data_q  <= extend(sel_mode, sel_imm);
              out_src_q   <= grant_b;
              out_valid_q <= 1'b1;
              state       <= OUT_HOLD;
            end
          end
        end
        PAIR_LO: begin
          // The low beat's mode field carries no meaning.
          if (accept) begin
            out_data_q  <= {hi_byte, sel_imm};
            out_src_q   <= owner;
            out_valid_q <= 1'b1;
            state       <= OUT_HOLD;
          end
        end
        OUT_HOLD: begin
          if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
            ptr         <= ~out_src_q;
            state       <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
